// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one byte per valid/ready handshake, sent LSB-first on a registered line.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx #(
    parameter int CLKS_1200 = 41667,
    parameter int CLKS_2400 = 20833,
    parameter int CLKS_4800 = 10417,
    parameter int CLKS_9600 = 5208
) (
    input  logic       clkRx,
    input  logic       resetreg,
    input  logic [1:0] baudRate,
    input  logic [7:0] txData,
    input  logic       txValid,
    output logic       txReady,
    output logic       serialOutput,
    output logic       busy,
    output logic       txDone
);

    localparam int MAX_LO  = (CLKS_1200 > CLKS_2400) ? CLKS_1200 : CLKS_2400;
    localparam int MAX_HI  = (CLKS_4800 > CLKS_9600) ? CLKS_4800 : CLKS_9600;
    localparam int MAX_CPB = (MAX_LO > MAX_HI) ? MAX_LO : MAX_HI;
    localparam int CNT_W   = $clog2(MAX_CPB + 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   clk_cnt_reg, clk_cnt_next;
    logic [CNT_W-1:0]   cpb_reg, cpb_next;
    logic [CNT_W-1:0]   cpb_sel;
    logic [2:0]         bit_cnt_reg, bit_cnt_next;
    logic [7:0]         shift_reg, shift_next;
    logic               serial_reg, serial_next;
    logic               bit_end;
`ifdef UART_TX_PARITY_EN
    logic               parity_reg, parity_next;
`endif

    always_comb begin
        case (baudRate)
            2'd0:    cpb_sel = CNT_W'(CLKS_1200);
            2'd1:    cpb_sel = CNT_W'(CLKS_2400);
            2'd2:    cpb_sel = CNT_W'(CLKS_4800);
            default: cpb_sel = CNT_W'(CLKS_9600);
        endcase
    end

    // Last clock of the current bit period; the rate is frozen in cpb_reg at accept.
    assign bit_end = (clk_cnt_reg == (cpb_reg - CNT_W'(1)));

    always_comb begin
        state_next   = state_reg;
        clk_cnt_next = clk_cnt_reg;
        cpb_next     = cpb_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        serial_next  = serial_reg;
`ifdef UART_TX_PARITY_EN
        parity_next  = parity_reg;
`endif
        case (state_reg)
            IDLE: begin
                serial_next = 1'b1;
                if (txValid && txReady) begin
                    shift_next   = txData;
                    cpb_next     = cpb_sel;
                    clk_cnt_next = '0;
                    bit_cnt_next = '0;
                    state_next   = START;
                    serial_next  = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_next  = ^txData;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    clk_cnt_next = '0;
                    state_next   = DATA;
                    serial_next  = shift_reg[0];
                end else begin
                    clk_cnt_next = clk_cnt_reg + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    clk_cnt_next = '0;
                    shift_next   = {1'b0, shift_reg[7:1]};
                    if (bit_cnt_reg == 3'd7) begin
                        bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
                        state_next   = PARITY;
                        serial_next  = parity_reg;
`else
                        state_next   = STOP;
                        serial_next  = 1'b1;
`endif
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        serial_next  = shift_reg[1];
                    end
                end else begin
                    clk_cnt_next = clk_cnt_reg + CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    clk_cnt_next = '0;
                    state_next   = STOP;
                    serial_next  = 1'b1;
                end else begin
                    clk_cnt_next = clk_cnt_reg + CNT_W'(1);
                end
            end
`endif
            STOP: begin
                serial_next = 1'b1;
                if (bit_end) begin
                    clk_cnt_next = '0;
                    state_next   = IDLE;
                end else begin
                    clk_cnt_next = clk_cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next  = IDLE;
                serial_next = 1'b1;
            end
        endcase
    end

    // Reset aborts any frame at once; the line returns high with no stop bit.
    always_ff @(posedge clkRx or posedge resetreg) begin
        if (resetreg) begin
            state_reg   <= IDLE;
            clk_cnt_reg <= '0;
            cpb_reg     <= CNT_W'(CLKS_9600);
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            serial_reg  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            clk_cnt_reg <= clk_cnt_next;
            cpb_reg     <= cpb_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            serial_reg  <= serial_next;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= parity_next;
`endif
        end
    end

    assign serialOutput = serial_reg;
    assign txReady      = (state_reg == IDLE);
    assign busy         = (state_reg != IDLE);
    assign txDone       = (state_reg == STOP) && bit_end;

endmodule
